song_recorder: RTL and testbench

//  Captures the live played note (keyboard or mic) into one of four 250-entry song slots of the

---
 rtl/song_pkg.sv | 40 ++++
 rtl/song_recorder_if.sv | 34 +++
 rtl/note_interval_timer.sv | 39 +++
 rtl/song_recorder.sv | 141 ++++++++++++++
 tb/tb_song_recorder.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/song_pkg.sv
// -----------------------------------------------------------------------------
// song_pkg
// Shared definitions for the song recorder, song playback and game_controller:
// note code width, slot geometry, special note codes, the default note length
// and the recorder state type. Also holds two small helpers used by the recorder.
// -----------------------------------------------------------------------------
package song_pkg;

   localparam int NOTE_BITS   = 7;
   localparam int ADDR_BITS   = 10;
   localparam int SLOT_SIZE   = 250;
   localparam int NOTE_LENGTH = 50_000_000;

   localparam logic [NOTE_BITS-1:0] NOTE_REST   = 7'd0;
   localparam logic [NOTE_BITS-1:0] SONG_FINISH = 7'h7F;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_RECORD,
      ST_TERMINATE,
      ST_DONE
   } rec_state_t;

   // First RAM word of a slot (slot * SLOT_SIZE).
   function automatic logic [ADDR_BITS-1:0] slot_base(input logic [1:0] slot);
      case (slot)
         2'd0:    return 10'd0;
         2'd1:    return 10'd250;
         2'd2:    return 10'd500;
         default: return 10'd750;
      endcase
   endfunction

   // A played 7'h7F must never land in RAM, or playback would stop early.
   function automatic logic [NOTE_BITS-1:0] store_note(input logic [NOTE_BITS-1:0] n);
      return (n == SONG_FINISH) ? NOTE_REST : n;
   endfunction

endpackage

// File: rtl/song_recorder_if.sv
// -----------------------------------------------------------------------------
// song_recorder_if
// Control and RAM-write-port bundle of the song recorder.
//   master : controller side (drives start/stop/song_slot/input_note,
//            observes the RAM write port and status)
//   slave  : recorder side
// Signals: start, stop (pulses), song_slot[1:0], input_note[6:0],
//          ram_we, ram_addr[9:0], ram_data[7:0], recording, done, note_count[7:0]
// -----------------------------------------------------------------------------
interface song_recorder_if;
   import song_pkg::*;

   logic                 start;
   logic                 stop;
   logic [1:0]           song_slot;
   logic [NOTE_BITS-1:0] input_note;
   logic                 ram_we;
   logic [ADDR_BITS-1:0] ram_addr;
   logic [7:0]           ram_data;
   logic                 recording;
   logic                 done;
   logic [7:0]           note_count;

   modport master (
      output start, stop, song_slot, input_note,
      input  ram_we, ram_addr, ram_data, recording, done, note_count
   );

   modport slave (
      input  start, stop, song_slot, input_note,
      output ram_we, ram_addr, ram_data, recording, done, note_count
   );

endinterface

// File: rtl/note_interval_timer.sv
// -----------------------------------------------------------------------------
// note_interval_timer
// Free-running counter 0..NOTE_LENGTH-1 while enabled, with a one-cycle tick on
// the last count. Shared between recording and playback.
// Ports:
//   clk_in    clock
//   rst_in    synchronous active-high reset
//   i_clear   force the count to 0 (takes priority over i_enable)
//   i_enable  advance the count
//   o_tick    high while enabled and the count equals NOTE_LENGTH-1
// -----------------------------------------------------------------------------
module note_interval_timer #(
   parameter int NOTE_LENGTH = 50_000_000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int CNT_W = (NOTE_LENGTH > 1) ? $clog2(NOTE_LENGTH) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NOTE_LENGTH - 1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == LAST);
   assign o_tick = i_enable && w_last;

   always_ff @(posedge clk_in) begin
      if (rst_in || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= w_last ? '0 : r_count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/song_recorder.sv
// -----------------------------------------------------------------------------
// song_recorder
// Records the live note into one of four 250-word song slots through RAM
// write port B: one word {1'b0, note} per note interval, then 8'h7F.
// Ports:
//   clk_in      system clock
//   rst_in      synchronous active-high reset (aborts a take, no terminator)
//   bus.slave   start/stop/song_slot/input_note in;
//               ram_we/ram_addr/ram_data/recording/done/note_count out
// All outputs are registered.
// -----------------------------------------------------------------------------
module song_recorder
   import song_pkg::*;
#(
   parameter int NOTE_LENGTH = song_pkg::NOTE_LENGTH,
   parameter bit WAIT_FIRST  = 1'b1
) (
   input  logic           clk_in,
   input  logic           rst_in,
   song_recorder_if.slave bus
);

   rec_state_t           r_state;
   rec_state_t           w_next;
   logic [ADDR_BITS-1:0] r_base;
   logic [7:0]           r_note_count;
   logic                 r_stop_pend;
   logic                 r_ram_we;
   logic [ADDR_BITS-1:0] r_ram_addr;
   logic [7:0]           r_ram_data;
   logic                 r_recording;
   logic                 r_done;

   logic                 w_in_record;
   logic                 w_tick;
   logic                 w_take;
   logic                 w_wr_note;
   logic                 w_wr_term;
   logic                 w_full;

   assign w_in_record = (r_state == ST_RECORD);
   assign w_full      = (r_note_count == 8'(SLOT_SIZE - 1));

   // Counter sits at 0 outside RECORD, so every take starts a fresh interval.
   note_interval_timer #(
      .NOTE_LENGTH (NOTE_LENGTH)
   ) u_timer (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .i_clear  (!w_in_record),
      .i_enable (w_in_record),
      .o_tick   (w_tick)
   );

   always_comb begin
      w_next    = r_state;
      w_take    = 1'b0;
      w_wr_note = 1'b0;
      w_wr_term = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               w_take = 1'b1;
               w_next = WAIT_FIRST ? ST_ARM : ST_RECORD;
            end
         end
         ST_ARM: begin
            if (bus.stop) begin
               w_wr_term = 1'b1;
               w_next    = ST_TERMINATE;
            end else if (bus.input_note != NOTE_REST) begin
               w_next = ST_RECORD;
            end
         end
         ST_RECORD: begin
            // The cycle after a note write (pending stop or slot full) is where
            // the terminator is issued, keeping it right behind the last note.
            if (r_stop_pend || w_full) begin
               w_wr_term = 1'b1;
               w_next    = ST_TERMINATE;
            end else if (w_tick) begin
               w_wr_note = 1'b1;
            end else if (bus.stop) begin
               w_wr_term = 1'b1;
               w_next    = ST_TERMINATE;
            end
         end
         ST_TERMINATE: begin
            w_next = ST_DONE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state      <= ST_IDLE;
         r_base       <= '0;
         r_note_count <= '0;
         r_stop_pend  <= 1'b0;
         r_ram_we     <= 1'b0;
         r_ram_addr   <= '0;
         r_ram_data   <= '0;
         r_recording  <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_ram_we    <= w_wr_note || w_wr_term;
         r_recording <= (w_next == ST_ARM) || (w_next == ST_RECORD);
         r_done      <= (w_next == ST_DONE);
         // A stop landing on a tick is remembered so the note is written first.
         r_stop_pend <= w_wr_note && bus.stop;

         if (w_take) begin
            r_base       <= slot_base(bus.song_slot);
            r_note_count <= '0;
         end

         if (w_wr_note) begin
            r_ram_addr   <= r_base + ADDR_BITS'(r_note_count);
            r_ram_data   <= {1'b0, store_note(bus.input_note)};
            r_note_count <= r_note_count + 8'd1;
         end

         if (w_wr_term) begin
            r_ram_addr <= r_base + ADDR_BITS'(r_note_count);
            r_ram_data <= {1'b0, SONG_FINISH};
         end
      end
   end

   assign bus.ram_we     = r_ram_we;
   assign bus.ram_addr   = r_ram_addr;
   assign bus.ram_data   = r_ram_data;
   assign bus.recording  = r_recording;
   assign bus.done       = r_done;
   assign bus.note_count = r_note_count;

endmodule

// File: tb/tb_song_recorder.sv
// -----------------------------------------------------------------------------
// tb_song_recorder
// Directed sequence of takes with randomized notes, slots, stop points and
// stray start pulses. Expected RAM writes (cycle, address, data) are derived
// from the note-interval arithmetic and compared with the writes seen on the bus.
// -----------------------------------------------------------------------------
module tb_song_recorder;

   localparam int NL = 4;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   logic clk_in = 1'b0;
   logic rst_in = 1'b1;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   wr_t  obs_q[$];
   wr_t  exp_q[$];

   song_recorder_if bus();

   song_recorder #(
      .NOTE_LENGTH (NL),
      .WAIT_FIRST  (1'b1)
   ) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   always @(posedge clk_in) cyc <= cyc + 1;

   always @(negedge clk_in) begin
      if (bus.ram_we === 1'b1)
         obs_q.push_back('{cyc, int'(bus.ram_addr), int'(bus.ram_data)});
   end

   task automatic tick1();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int san(input int n);
      return (n == 127) ? 0 : n;
   endfunction

   task automatic compare_writes(input string tag);
      int n;
      check({tag, "_nwrites"}, obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_cyc"},  obs_q[i].cyc,  exp_q[i].cyc);
         check({tag, "_addr"}, obs_q[i].addr, exp_q[i].addr);
         check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      end
      obs_q.delete();
      exp_q.delete();
   endtask

   // One take: nnotes full intervals, then stop stop_off cycles after the last
   // tick (0 = on the tick itself).
   task automatic run_take(input int slot, input int nnotes, input int stop_off,
                           input bit force7f, input bit start_with_stop, input string tag);
      int base;
      int a;
      int t;
      int notes[$];
      base = slot * 250;
      bus.start      = 1'b1;
      bus.stop       = start_with_stop;
      bus.song_slot  = 2'(slot);
      bus.input_note = '0;
      tick1();
      bus.start     = 1'b0;
      bus.stop      = 1'b0;
      bus.song_slot = 2'($urandom);
      check({tag, "_arm_rec"},   bus.recording,  1);
      check({tag, "_arm_done"},  bus.done,       0);
      check({tag, "_arm_count"}, bus.note_count, 0);
      repeat ($urandom_range(0, 5)) tick1();
      check({tag, "_arm_nowrite"}, obs_q.size(), 0);
      for (int j = 0; j < nnotes; j++) notes.push_back(int'($urandom_range(0, 127)));
      if (force7f) notes[nnotes-1] = 127;
      a = cyc;
      t = a + NL * nnotes + stop_off;
      for (int c = a; c <= t; c++) begin
         bus.stop = (c == t);
         if (c > a && (c - a) % NL == 0)
            bus.input_note = 7'(notes[(c - a) / NL - 1]);
         else
            bus.input_note = 7'($urandom_range(1, 127));
         bus.start     = (c > a) && (c < t) && ($urandom_range(0, 7) == 0);
         bus.song_slot = 2'($urandom);
         tick1();
      end
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.input_note = '0;
      for (int j = 0; j < nnotes; j++)
         exp_q.push_back('{a + NL * (j + 1) + 1, base + j, san(notes[j])});
      exp_q.push_back('{t + 1 + ((stop_off == 0) ? 1 : 0), base + nnotes, 127});
      repeat (4) tick1();
      compare_writes(tag);
      check({tag, "_done"},  bus.done,       1);
      check({tag, "_rec"},   bus.recording,  0);
      check({tag, "_count"}, bus.note_count, nnotes);
   endtask

   initial begin
      int a;
      int slot;
      bus.start      = 1'b0;
      bus.stop       = 1'b0;
      bus.song_slot  = '0;
      bus.input_note = '0;

      // Reset, then idle with stray stop pulses.
      rst_in = 1'b1;
      repeat (3) tick1();
      rst_in = 1'b0;
      obs_q.delete();
      check("rst_we",    bus.ram_we,     0);
      check("rst_addr",  bus.ram_addr,   0);
      check("rst_data",  bus.ram_data,   0);
      check("rst_rec",   bus.recording,  0);
      check("rst_done",  bus.done,       0);
      check("rst_count", bus.note_count, 0);
      for (int i = 0; i < 20; i++) begin
         bus.stop       = (i % 5 == 2);
         bus.input_note = 7'($urandom);
         tick1();
      end
      bus.stop       = 1'b0;
      bus.input_note = '0;
      check("idle_writes", obs_q.size(), 0);
      check("idle_rec",    bus.recording, 0);
      check("idle_done",   bus.done,      0);

      // Slot 2, stop mid-interval.
      run_take(2, 3, 2, 1'b0, 1'b0, "slot2");
      // Slot 1 from DONE, start and stop together (start wins).
      run_take(1, 3, $urandom_range(1, NL - 1), 1'b0, 1'b1, "slot1");
      // Last sampled note is 7'h7F, stop on the tick.
      run_take($urandom_range(0, 3), $urandom_range(2, 6), 0, 1'b1, 1'b0, "ff_tick");
      // Random takes.
      for (int k = 0; k < 3; k++)
         run_take($urandom_range(0, 3), $urandom_range(1, 8), $urandom_range(0, NL - 1),
                  1'b0, 1'b0, "rand");

      // Stop while still armed: zero-note take.
      slot = $urandom_range(0, 3);
      bus.start     = 1'b1;
      bus.song_slot = 2'(slot);
      tick1();
      bus.start = 1'b0;
      repeat (3) tick1();
      bus.stop = 1'b1;
      a = cyc;
      tick1();
      bus.stop = 1'b0;
      exp_q.push_back('{a + 1, slot * 250, 127});
      repeat (4) tick1();
      compare_writes("armstop");
      check("armstop_count", bus.note_count, 0);
      check("armstop_done",  bus.done,       1);

      // Slot 3 held on note 5 until the slot fills.
      bus.start     = 1'b1;
      bus.song_slot = 2'd3;
      tick1();
      bus.start = 1'b0;
      repeat (2) tick1();
      bus.input_note = 7'd5;
      a = cyc;
      for (int c = a; c < a + NL * 249 + 6; c++) tick1();
      bus.input_note = '0;
      for (int j = 0; j < 249; j++) exp_q.push_back('{a + NL * (j + 1) + 1, 750 + j, 5});
      exp_q.push_back('{a + NL * 249 + 2, 999, 127});
      compare_writes("full");
      check("full_count", bus.note_count, 249);
      check("full_done",  bus.done,       1);

      // Re-arm from DONE, then reset mid-RECORD.
      bus.start     = 1'b1;
      bus.song_slot = 2'd0;
      tick1();
      bus.start = 1'b0;
      check("rearm_done",  bus.done,       0);
      check("rearm_count", bus.note_count, 0);
      check("rearm_rec",   bus.recording,  1);
      bus.input_note = 7'd33;
      a = cyc;
      for (int c = a; c <= a + NL + 1; c++) tick1();
      rst_in = 1'b1;
      tick1();
      rst_in = 1'b0;
      check("abort_rec",   bus.recording,  0);
      check("abort_done",  bus.done,       0);
      check("abort_count", bus.note_count, 0);
      check("abort_we",    bus.ram_we,     0);
      repeat (6) tick1();
      bus.input_note = '0;
      exp_q.push_back('{a + NL + 1, 0, 33});
      compare_writes("abort");
      check("abort_idle_rec", bus.recording, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
